// File: rtl/pll_ctrl_pkg.sv
// Shared state type and parameter defaults for the PLL reset sequencer.
package pll_ctrl_pkg;

  localparam int unsigned PLL_RST_CYCLES_DEF = 16;
  localparam int unsigned STABLE_CYCLES_DEF  = 1024;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 65536;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } pll_state_t;

  // Largest of three cycle counts, floored at 2 so the counter is never zero-width.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 2 : m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset; re-resets the PLL on timeout or software restart.
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_ok,
  output logic [7:0] loss_count
);

  localparam int unsigned CNT_W = $clog2(max3(PLL_RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES));

  localparam logic [CNT_W-1:0] C_PRST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  pll_state_t       r_state;
  pll_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_loss;
  logic [7:0]       w_loss_nxt;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_lock_ok;
  logic             w_locked_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_locked_s)
  );

  // Next-state, counter and loss-count logic; restart outranks every state rule.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss_nxt  = r_loss;
    if (restart && (r_state != ST_PLL_RST)) begin
      w_state_nxt = ST_PLL_RST;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == C_PRST_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_TOUT_LAST) begin
            w_state_nxt = ST_PLL_RST;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_STAB_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
            if (r_loss != 8'hFF) w_loss_nxt = r_loss + 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_PLL_RST;
      r_cnt     <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_lock_ok <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_loss    <= w_loss_nxt;
      r_pll_rst <= (w_state_nxt == ST_PLL_RST);
      r_sys_rst <= (w_state_nxt != ST_RUN);
      r_lock_ok <= (w_state_nxt == ST_RUN);
    end
  end

  assign pll_rst    = r_pll_rst;
  assign sys_rst    = r_sys_rst;
  assign lock_ok    = r_lock_ok;
  assign loss_count = r_loss;

endmodule
